// File: rtl/gate_pipe_unit.sv
// Pipelined bitwise gate unit: per-beat opcode selects one of 15 gate functions or a
// running XOR accumulator; results travel through STAGES registers behind valid/ready.
module gate_bit (
  input  logic [3:0] op,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       acc,
  output logic       y
);
  always_comb begin
    y = 1'b0;
    case (op)
      4'h0: y = ~a;
      4'h1: y = a & b;
      4'h2: y = ~(a & b);
      4'h3: y = a & ~b;
      4'h4: y = a | b;
      4'h5: y = ~(a | b);
      4'h6: y = a | ~b;
      4'h7: y = a ^ b;
      4'h8: y = ~(a ^ b);
      4'h9: y = ~((a & b) | c);
      4'hA: y = ~((a | b) & c);
      4'hB: y = ~((a & b) | (c & d));
      4'hC: y = ~((a | b) & (c | d));
      4'hD: y = c ? b : a;
      4'hE: y = ~(c ? b : a);
      4'hF: y = acc ^ a;
    endcase
  end
endmodule

module gate_pipe_unit #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic             in_last,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);
  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic              advance;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  res;
  logic [STAGES:1]   vld_pipe;
  beat_t [STAGES:1]  beat_pipe;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gate_bit u_bit (
      .op  (in_op),
      .a   (in_a[i]),
      .b   (in_b[i]),
      .c   (in_c[i]),
      .d   (in_d[i]),
      .acc (acc[i]),
      .y   (res[i])
    );
  end

  // Whole pipe moves in lockstep; bubbles stay in place rather than collapsing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      beat_pipe <= '0;
    end else if (advance) begin
      vld_pipe[1]  <= in_valid;
      beat_pipe[1] <= '{last: in_last, data: res};
      for (int k = 2; k <= STAGES; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        beat_pipe[k] <= beat_pipe[k-1];
      end
    end
  end

  // Accumulator only reacts to accepted ACC beats; last clears it after its use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (in_valid && in_ready && in_op == 4'hF)
      acc <= in_last ? '0 : (acc ^ in_a);
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_data  = beat_pipe[STAGES].data;
  assign out_last  = beat_pipe[STAGES].last;
endmodule

// File: tb/tb_gate_pipe_unit.sv
// Directed bench for gate_pipe_unit (WIDTH=8, STAGES=2): vector table plus
// hand sequences for reset, back-pressure and bubbles, with an output scoreboard.
module tb_gate_pipe_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_last;
  logic [3:0] in_op;
  logic [7:0] in_a, in_b, in_c, in_d;
  logic       out_valid, out_ready, out_last;
  logic [7:0] out_data;

  int checks = 0;
  int failures = 0;

  gate_pipe_unit #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_last(in_last),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, c, d;
    logic       last;
    logic [7:0] exp;
  } vec_t;

  vec_t       tv[$];
  logic [8:0] expq[$];
  bit         mon_en = 1'b0;
  bit         stalled = 1'b0;
  logic [8:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [7:0] a, b, c, d,
                     input logic last, input logic [7:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.c = c; v.d = d; v.last = last; v.exp = exp;
    tv.push_back(v);
  endtask

  // Scoreboard: in-order compare on every transfer, hold check on every stall.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (stalled) begin
        chk("stall_valid_hold", {31'd0, out_valid}, 32'd1);
        chk("stall_data_hold", {23'd0, out_last, out_data}, {23'd0, held});
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_output", {23'd0, out_last, out_data}, 32'hFFFF_FFFF);
        end else begin
          logic [8:0] e;
          e = expq.pop_front();
          chk("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
          chk("out_last", {31'd0, out_last}, {31'd0, e[8]});
        end
      end
      stalled = out_valid && !out_ready;
      held    = {out_last, out_data};
    end else begin
      stalled = 1'b0;
    end
  end

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send(input logic [3:0] op, input logic [7:0] a, b, c, d,
                      input logic last, input logic [7:0] exp);
    bit done = 1'b0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_c = c; in_d = d; in_last = last;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        expq.push_back({last, exp});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && expq.size() != 0; n++) @(negedge clk);
    chk("drain_empty", expq.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [9:0] pat;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_last = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // All gate opcodes on a=F0 b=CC c=AA d=0F
    add(4'h0, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b1, 8'h0F);
    add(4'h1, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b0, 8'hC0);
    add(4'h2, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b0, 8'h3F);
    add(4'h3, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b0, 8'h30);
    add(4'h4, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b0, 8'hFC);
    add(4'h5, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b0, 8'h03);
    add(4'h6, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b0, 8'hF3);
    add(4'h7, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b0, 8'h3C);
    add(4'h8, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b0, 8'hC3);
    add(4'h9, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b0, 8'h15);
    add(4'hA, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b0, 8'h57);
    add(4'hB, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b0, 8'h35);
    add(4'hC, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b0, 8'h53);
    add(4'hD, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b0, 8'hD8);
    add(4'hE, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b0, 8'h27);
    // ACC stream; last clears after use
    add(4'hF, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 8'h01);
    add(4'hF, 8'h02, 8'h00, 8'h00, 8'h00, 1'b0, 8'h03);
    add(4'hF, 8'h04, 8'h00, 8'h00, 8'h00, 1'b1, 8'h07);
    add(4'hF, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0, 8'h08);
    add(4'hF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h08);
    // Interleave: non-ACC last leaves acc alone
    add(4'hF, 8'h11, 8'h00, 8'h00, 8'h00, 1'b0, 8'h11);
    add(4'h1, 8'hFF, 8'h0F, 8'h00, 8'h00, 1'b1, 8'h0F);
    add(4'hF, 8'h22, 8'h00, 8'h00, 8'h00, 1'b0, 8'h33);
    add(4'hF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 8'hCC);

    foreach (tv[i]) send(tv[i].op, tv[i].a, tv[i].b, tv[i].c, tv[i].d, tv[i].last, tv[i].exp);
    drain();

    // Back-pressure: 4 beats, output stalled 3 cycles after the first result
    fork
      begin
        for (int k = 0; k < 4; k++)
          send(4'h4, 8'h01 << k, 8'h80, 8'h00, 8'h00, k == 3, (8'h01 << k) | 8'h80);
      end
      begin
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Bubbles: out_valid follows in_valid two cycles later
    pat = 10'b00_1011_0101;
    for (int i = 0; i < 10; i++) begin
      logic ev;
      in_valid = pat[i]; in_op = 4'h7; in_a = 8'(i); in_b = 8'h5A; in_last = 1'b0;
      if (pat[i]) expq.push_back({1'b0, 8'(i) ^ 8'h5A});
      @(negedge clk);
      ev = 1'b0;
      if (i >= 2) ev = pat[i-2];
      chk("bubble_in_ready", {31'd0, in_ready}, 32'd1);
      chk("bubble_out_valid", {31'd0, out_valid}, {31'd0, ev});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Reset mid-stream discards in-flight beats and the accumulator
    mon_en = 1'b0;
    in_valid = 1'b1; in_op = 4'hF; in_a = 8'h5A; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_valid_before_rst", {31'd0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_data", {24'd0, out_data}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    send(4'hF, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0, 8'h05);
    send(4'hF, 8'h30, 8'h00, 8'h00, 8'h00, 1'b1, 8'h35);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
